// File: rtl/crc_serial_engine_pkg.sv
// crc_serial_engine_pkg: FSM state encoding and named generator polynomials for the serial CRC engine.
package crc_serial_engine_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;
  localparam logic [7:0]  CRC8_SMBUS  = 8'h07;
  localparam logic [15:0] CRC16_CCITT = 16'h1021;
  localparam logic [31:0] CRC32       = 32'h04C11DB7;
endpackage

// File: rtl/crc_serial_engine_step.sv
// crc_serial_engine_step: xor_gate primitive and the single-bit CRC feedback step built from it.
module xor_gate (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  assign o_y = i_a ^ i_b;
endmodule

module crc_step #(
  parameter int               CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = 8'h07
) (
  input  logic [CRC_W-1:0] i_crc_in,
  input  logic             i_data_bit,
  output logic [CRC_W-1:0] o_crc_out
);
  logic w_fb;
  xor_gate u_fb (.i_a(i_crc_in[CRC_W-1]), .i_b(i_data_bit), .o_y(w_fb));
  assign o_crc_out[0] = POLY[0] & w_fb;
  // Gates exist only at tap positions; other bits are plain shifts.
  for (genvar i = 1; i < CRC_W; i++) begin : g_bit
    if (POLY[i]) begin : g_tap
      xor_gate u_x (.i_a(i_crc_in[i-1]), .i_b(w_fb), .o_y(o_crc_out[i]));
    end else begin : g_pass
      assign o_crc_out[i] = i_crc_in[i-1];
    end
  end
endmodule

// File: rtl/crc_serial_engine.sv
// crc_serial_engine: bit-serial MSB-first CRC/LFSR over valid/ready words, result on a valid/ready output.
module crc_serial_engine
  import crc_serial_engine_pkg::*;
#(
  parameter int               CRC_W   = 8,
  parameter logic [CRC_W-1:0] POLY    = CRC8_SMBUS,
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter int               DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  out_crc
);
  localparam int CW = $clog2(DATA_W + 1);
  state_t            r_state, w_next;
  logic [CRC_W-1:0]  r_crc, w_step;
  logic [DATA_W-1:0] r_sh;
  logic [CW-1:0]     r_bit_cnt;
  logic              r_last;
  logic              w_acc;
  assign in_ready  = (r_state == IDLE) || (r_state == WAIT);
  assign out_valid = r_state == DONE;
  assign out_crc   = r_crc ^ XOR_OUT;
  assign w_acc     = in_valid & in_ready;
  crc_step #(.CRC_W(CRC_W), .POLY(POLY)) u_step (
    .i_crc_in  (r_crc),
    .i_data_bit(r_sh[DATA_W-1]),
    .o_crc_out (w_step)
  );
  always_comb begin
    w_next = r_state;
    if (w_acc) w_next = SHIFT;
    else if (r_state == SHIFT && r_bit_cnt == CW'(1)) w_next = r_last ? DONE : WAIT;
    else if (r_state == DONE && out_ready) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // The CRC restarts only when a word is taken from IDLE; words taken in WAIT continue the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc     <= INIT;
      r_sh      <= '0;
      r_bit_cnt <= '0;
      r_last    <= 1'b0;
    end else if (w_acc) begin
      r_sh      <= in_data;
      r_last    <= in_last;
      r_bit_cnt <= CW'(DATA_W);
      if (r_state == IDLE) r_crc <= INIT;
    end else if (r_state == SHIFT) begin
      r_crc     <= w_step;
      r_sh      <= r_sh << 1;
      r_bit_cnt <= r_bit_cnt - CW'(1);
    end
  end
endmodule

// File: tb/tb_crc_serial_engine.sv
// tb_crc_serial_engine: directed frames on a CRC-8 and a CRC-16 instance; a monitor checks results from a queue.
module tb_crc_serial_engine;
  import crc_serial_engine_pkg::*;
  logic        clk, rst;
  logic [7:0]  din;
  logic        dlast;
  logic        v8, v16, rdy8, rdy16, ov8, ov16, or8, or16;
  logic [7:0]  crc8;
  logic [15:0] crc16;
  logic [31:0] q8[$], q16[$];
  int tests = 0, fails = 0;
  crc_serial_engine u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_data(din), .in_last(dlast),
    .out_valid(ov8), .out_ready(or8), .out_crc(crc8)
  );
  crc_serial_engine #(
    .CRC_W(16), .POLY(CRC16_CCITT), .INIT(16'hFFFF), .XOR_OUT(16'h0000), .DATA_W(8)
  ) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .in_data(din), .in_last(dlast),
    .out_valid(ov16), .out_ready(or16), .out_crc(crc16)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h required %h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (ov8 && or8) begin
      if (q8.size() == 0) begin
        tests++; fails++;
        $display("FAIL crc8 unexpected result: got %h required none", crc8);
      end else chk("crc8 result", 32'(crc8), q8.pop_front());
    end
    if (ov16 && or16) begin
      if (q16.size() == 0) begin
        tests++; fails++;
        $display("FAIL crc16 unexpected result: got %h required none", crc16);
      end else chk("crc16 result", 32'(crc16), q16.pop_front());
    end
  end
  task automatic send(input bit s, input logic [7:0] d, input bit last, input int ns);
    int n = 0;
    din = d;
    dlast = last;
    if (s) v16 = 1'b1; else v8 = 1'b1;
    while (!(s ? rdy16 : rdy8) && n < 50) begin step(); n++; end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL accept timeout: got in_ready=0 required 1");
    end
    step();
    v8 = 1'b0;
    v16 = 1'b0;
    for (int i = 0; i < ns; i++) begin
      chk("in_ready low in SHIFT", 32'(s ? rdy16 : rdy8), 0);
      chk("out_valid low in SHIFT", 32'(s ? ov16 : ov8), 0);
      step();
    end
    if (ns == 8) chk(last ? "out_valid after last word" : "in_ready in WAIT",
                     32'(last ? (s ? ov16 : ov8) : (s ? rdy16 : rdy8)), 1);
  endtask
  initial begin
    rst = 1'b1; v8 = 1'b0; v16 = 1'b0; din = '0; dlast = 1'b0; or8 = 1'b1; or16 = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("reset in_ready8", 32'(rdy8), 1);
    chk("reset out_valid8", 32'(ov8), 0);
    chk("reset crc8", 32'(crc8), 32'h00);
    chk("reset in_ready16", 32'(rdy16), 1);
    chk("reset out_valid16", 32'(ov16), 0);
    chk("reset crc16", 32'(crc16), 32'hFFFF);
    q8.push_back(32'h07); send(0, 8'h01, 1, 8); step();
    q8.push_back(32'h89); send(0, 8'h80, 1, 8); step();
    q8.push_back(32'h00); send(0, 8'h00, 1, 8); step();
    q8.push_back(32'hF4);
    for (int i = 0; i < 9; i++) begin
      send(0, 8'h31 + 8'(i), i == 8, 8);
      repeat ($urandom_range(0, 3)) step();
    end
    step();
    q16.push_back(32'h29B1);
    for (int i = 0; i < 9; i++) begin
      send(1, 8'h31 + 8'(i), i == 8, 8);
      repeat ($urandom_range(0, 3)) step();
    end
    step(); step();
    or8 = 1'b0;
    q8.push_back(32'h07);
    send(0, 8'h01, 1, 8);
    for (int i = 0; i < 5; i++) begin
      v8 = 1'b1; din = 8'hAA; dlast = 1'b1;
      chk("hold crc8 stable", 32'(crc8), 32'h07);
      chk("hold in_ready low", 32'(rdy8), 0);
      chk("hold out_valid high", 32'(ov8), 1);
      step();
    end
    v8 = 1'b0;
    or8 = 1'b1;
    step();
    chk("idle after handshake in_ready", 32'(rdy8), 1);
    chk("idle after handshake out_valid", 32'(ov8), 0);
    q8.push_back(32'h89); send(0, 8'h80, 1, 8); step(); step();
    send(0, 8'h31, 0, 8);
    send(0, 8'h32, 0, 8);
    send(0, 8'h33, 0, 0);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid-shift reset in_ready", 32'(rdy8), 1);
    chk("mid-shift reset out_valid", 32'(ov8), 0);
    q8.push_back(32'h97); send(0, 8'h31, 1, 8);
    repeat (4) step();
    chk("crc8 queue drained", 32'(q8.size()), 0);
    chk("crc16 queue drained", 32'(q16.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/crc_serial_engine.md
Name: crc_serial_engine

Overview:
- Parametrised, bit-serial CRC/LFSR engine built around an XOR feedback step.
- Absorbs a frame of DATA_W-bit words over a valid/ready input, shifting one bit per clock, MSB first.
- Presents the final CRC over a valid/ready output.
- Sits beside the ALU datapath as the team's first sequential XOR-based block; used for frame checking and pseudo-random sequences.

Parameters:
- CRC_W, 8, CRC register width in bits (2..32).
- POLY, 8'h07, generator polynomial without the implicit x^CRC_W term; CRC_W bits wide.
- INIT, 8'h00, CRC register value loaded at the start of every frame.
- XOR_OUT, 8'h00, value XORed onto the CRC when it is presented on out_crc.
- DATA_W, 8, input word width (1..32).

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data and in_last are valid.
- in_ready  output  1  engine accepts a word this cycle.
- in_data  input  DATA_W  word to absorb; bit DATA_W-1 is shifted first.
- in_last  input  1  marks the final word of the frame.
- out_valid  output  1  out_crc holds a finished result.
- out_ready  input  1  consumer takes the result.
- out_crc  output  CRC_W  crc_reg XOR XOR_OUT; valid only while out_valid=1.

Behaviour:
- State machine states: IDLE, SHIFT, WAIT, DONE.
- Internal registers: crc_reg[CRC_W], shreg[DATA_W], bit_cnt (width clog2(DATA_W+1)), last_q.
- Reset (rst=1 at any edge, any state, including mid-SHIFT):
  - state=IDLE, crc_reg=INIT, bit_cnt=0, last_q=0.
  - Outputs after reset: in_ready=1, out_valid=0, out_crc = INIT^XOR_OUT (don't-care).
  - A partially absorbed frame is discarded.
- in_ready=1 only in IDLE and WAIT. out_valid=1 only in DONE. Both are decoded from state (Moore).
- Accept = in_valid & in_ready at an edge:
  - shreg <= in_data, last_q <= in_last, bit_cnt <= DATA_W, state <= SHIFT.
  - In IDLE only, crc_reg <= INIT at the same edge.
- SHIFT, each edge:
  - fb = crc_reg[CRC_W-1] ^ shreg[DATA_W-1].
  - crc_reg <= {crc_reg[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
  - shreg <= shreg<<1; bit_cnt <= bit_cnt-1.
- Exit from SHIFT: on the edge where bit_cnt==1, go to DONE if last_q, else WAIT.
- Latency: word accepted at edge E0; its bits are absorbed at edges E1..E_DATA_W. For a last word, out_valid is high in the cycle following E_DATA_W.
  - Throughput: one word per DATA_W+1 cycles at best.
- WAIT: crc_reg holds. Waits indefinitely for the next word; no timeout.
- DONE:
  - out_crc = crc_reg ^ XOR_OUT, held stable while out_valid=1 and out_ready=0.
  - On out_ready=1: state <= IDLE.
  - in_ready=0 in DONE, so in_valid there is ignored. A new frame is accepted at the earliest one cycle after the handshake.
- in_valid while in SHIFT is ignored (in_ready=0); the producer must hold the word.
- in_valid may drop in WAIT without effect.
- A single-word frame (in_last on the first word) is legal.
- DATA_W=1 degenerates to a pure serial LFSR: one SHIFT cycle per word.
- Arithmetic is modulo 2 only; there are no carries. All widths are fixed by the parameters; POLY, INIT and XOR_OUT are truncated to CRC_W.

Decomposition:
- Shared package/include crc_defs:
  - state encoding constants (IDLE=2'd0, SHIFT=2'd1, WAIT=2'd2, DONE=2'd3).
  - Named polynomial constants: CRC8_SMBUS=8'h07, CRC16_CCITT=16'h1021, CRC32=32'h04C11DB7.
- One sub-module, crc_step, is the natural split:
  - Combinational single-bit feedback step (crc_in, data_bit -> crc_out), parametrised by CRC_W and POLY.
  - Built from the team's xor_gate primitives so the step stays switch-level compatible.
- The FSM, counter and handshake stay in crc_serial_engine.

Test Plan:
- Defaults; single frame in_data=8'h01, in_last=1 -> out_valid rises exactly 9 cycles after the accept edge; out_crc=8'h07.
- Defaults; single frame 8'h80 -> out_crc=8'h89. Single frame 8'h00 -> out_crc=8'h00.
- Defaults; frame "123456789" (8'h31..8'h39, last on 8'h39) with random 0-3 idle cycles between words -> out_crc=8'hF4; in_ready=0 throughout every SHIFT.
- CRC_W=16, POLY=16'h1021, INIT=16'hFFFF, DATA_W=8, same "123456789" frame -> out_crc=16'h29B1.
- Hold out_ready=0 for 5 cycles in DONE -> out_crc stable, in_ready=0, in_valid ignored. Then out_ready=1 -> IDLE next cycle; a back-to-back new frame restarts from INIT.
- Assert rst for 1 cycle at SHIFT bit 4 of word 3 -> next cycle: IDLE, in_ready=1, out_valid=0. A subsequent "1" (8'h31) single-word frame returns the correct fresh CRC (8'h97 with defaults).
